// File: rtl/ahblite_bram_ctrl.sv
// ahblite_bram_ctrl: AHB-Lite slave that fronts a simple dual-port block RAM
// with a one-cycle registered read port and per-byte write enables.
// Writes complete at zero wait states: the RAM is written in the data phase.
// A read that hits the word being written in the same cycle is a hazard.
// The RAM returns the old word in that case, so it needs special handling.
// Optional build macro:
//   BRAM_WRITE_FORWARD_EN - resolve the hazard by merging the written bytes
//                           into the read data with no wait state. When the
//                           macro is undefined, the controller inserts one
//                           wait state and re-reads the RAM instead.
module ahblite_bram_ctrl #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [ADDR_WIDTH-1:0] BRAM_RDADDR,
  input  logic [31:0]           BRAM_RDATA,
  output logic [ADDR_WIDTH-1:0] BRAM_WRADDR,
  output logic [31:0]           BRAM_WDATA,
  output logic [3:0]            BRAM_WRITE
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic                  r_wr_pending;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [3:0]            r_wr_mask;
  logic                  r_rd_pending;
  logic [ADDR_WIDTH-1:0] r_rd_addr;

  logic [ADDR_WIDTH-1:0] w_word;
  logic [3:0]            w_mask;
  logic                  w_misaligned;
  logic                  w_can_accept;
  logic                  w_accept;
  logic                  w_accept_ok;
  logic                  w_hazard;
  logic                  w_stall;
  logic [31:0]           w_rdata;

  // Address bits above the RAM word range and HTRANS[0] (SEQ vs NONSEQ)
  // carry no meaning for this slave.
  logic [32-ADDR_WIDTH-2:0] w_unused_bits;
  assign w_unused_bits = {HTRANS[0], HADDR[31:ADDR_WIDTH+2]};

  assign w_word = HADDR[ADDR_WIDTH+1:2];

  // Only IDLE and ERR2 drive HREADYOUT high, so only they can take a new
  // address phase.
  assign w_can_accept = (r_state == ST_IDLE) || (r_state == ST_ERR2);
  assign w_accept     = HSEL & HTRANS[1] & HREADY & w_can_accept;
  assign w_accept_ok  = w_accept & ~w_misaligned;

  // The read address phase overlaps a write data phase to the same word.
  assign w_hazard = w_accept_ok & ~HWRITE & r_wr_pending & (r_wr_addr == w_word);

`ifdef BRAM_WRITE_FORWARD_EN
  assign w_stall = 1'b0;
`else
  assign w_stall = w_hazard;
`endif

  // Byte-lane mask and alignment check for the transfer in the address phase
  always_comb begin
    w_mask       = 4'b0000;
    w_misaligned = 1'b0;
    case (HSIZE)
      3'd0: w_mask = 4'b0001 << HADDR[1:0];
      3'd1: begin
        w_mask       = HADDR[1] ? 4'b1100 : 4'b0011;
        w_misaligned = HADDR[0];
      end
      3'd2: begin
        w_mask       = 4'b1111;
        w_misaligned = (HADDR[1:0] != 2'b00);
      end
      default: w_misaligned = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic and bus response outputs
  always_comb begin
    w_state_next = r_state;
    HREADYOUT    = 1'b1;
    HRESP        = 1'b0;
    case (r_state)
      ST_IDLE, ST_ERR2: begin
        HRESP = (r_state == ST_ERR2);
        if (w_accept && w_misaligned) w_state_next = ST_ERR1;
        else if (w_stall)             w_state_next = ST_WAIT;
        else                          w_state_next = ST_IDLE;
      end
      ST_ERR1: begin
        HREADYOUT    = 1'b0;
        HRESP        = 1'b1;
        w_state_next = ST_ERR2;
      end
      ST_WAIT: begin
        HREADYOUT    = 1'b0;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Write data phase bookkeeping: address and mask captured in the address phase
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_wr_pending <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_mask    <= 4'b0000;
    end else begin
      r_wr_pending <= w_accept_ok & HWRITE;
      if (w_accept_ok && HWRITE) begin
        r_wr_addr <= w_word;
        r_wr_mask <= w_mask;
      end
    end
  end

  // Read data phase bookkeeping; a stalled read becomes active after WAIT
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_rd_pending <= 1'b0;
      r_rd_addr    <= '0;
    end else begin
      r_rd_pending <= (w_accept_ok & ~HWRITE & ~w_stall) | (r_state == ST_WAIT);
      if (w_accept_ok && !HWRITE) r_rd_addr <= w_word;
    end
  end

`ifdef BRAM_WRITE_FORWARD_EN
  logic [3:0]  r_fwd_mask;
  logic [31:0] r_fwd_data;

  // Capture the bytes written in the hazard cycle so the read can see them
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_fwd_mask <= 4'b0000;
      r_fwd_data <= 32'h0;
    end else begin
      r_fwd_mask <= w_hazard ? r_wr_mask : 4'b0000;
      if (w_hazard) r_fwd_data <= HWDATA;
    end
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
`ifdef BRAM_WRITE_FORWARD_EN
      assign w_rdata[8*gi +: 8] = r_fwd_mask[gi] ? r_fwd_data[8*gi +: 8]
                                                 : BRAM_RDATA[8*gi +: 8];
`else
      assign w_rdata[8*gi +: 8] = BRAM_RDATA[8*gi +: 8];
`endif
    end
  endgenerate

  assign HRDATA = r_rd_pending ? w_rdata : 32'h0;

  // During WAIT the RAM is re-read at the stalled address, now updated
  assign BRAM_RDADDR = (r_state == ST_WAIT) ? r_rd_addr : w_word;
  assign BRAM_WRADDR = r_wr_addr;
  assign BRAM_WDATA  = HWDATA;
  assign BRAM_WRITE  = r_wr_pending ? r_wr_mask : 4'b0000;

endmodule

// File: tb/tb_ahblite_bram_ctrl.sv
// Testbench for ahblite_bram_ctrl. The driver issues AHB-Lite transfers and
// pushes the expected response of each one into a queue. It computes that
// response from a word-array memory model that is updated in issue order.
// A monitor on the falling clock edge tracks data phases and pops and
// compares. It also checks the RAM write strobes.
module tb_ahblite_bram_ctrl;

  localparam int AW    = 14;
  localparam int DEPTH = 1 << AW;
`ifdef BRAM_WRITE_FORWARD_EN
  localparam int HAZ_WAITS = 0;
`else
  localparam int HAZ_WAITS = 1;
`endif

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic [AW-1:0] BRAM_RDADDR;
  logic [31:0]   BRAM_RDATA;
  logic [AW-1:0] BRAM_WRADDR;
  logic [31:0]   BRAM_WDATA;
  logic [3:0]    BRAM_WRITE;

  assign HREADY = HREADYOUT;

  always #5 HCLK = ~HCLK;

  ahblite_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .BRAM_RDADDR(BRAM_RDADDR), .BRAM_RDATA(BRAM_RDATA),
    .BRAM_WRADDR(BRAM_WRADDR), .BRAM_WDATA(BRAM_WDATA), .BRAM_WRITE(BRAM_WRITE)
  );

  function automatic logic [31:0] init_val(input logic [AW-1:0] a);
    return ({18'h0, a} * 32'h9E3779B9) ^ 32'hA5C31E0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Block RAM model: registered read-first port, byte-enabled write port
  logic [31:0] bram [0:DEPTH-1];
  bit          bram_written [0:DEPTH-1];

  function automatic logic [31:0] bram_word(input logic [AW-1:0] a);
    return bram_written[a] ? bram[a] : init_val(a);
  endfunction

  always @(posedge HCLK) begin
    BRAM_RDATA <= bram_word(BRAM_RDADDR);
    if (BRAM_WRITE != 4'b0000) begin
      bram[BRAM_WRADDR]         <= merge(bram_word(BRAM_WRADDR), BRAM_WDATA, BRAM_WRITE);
      bram_written[BRAM_WRADDR] <= 1'b1;
    end
  end

  // Reference model and scoreboard
  typedef struct {
    int            id;
    bit            is_write;
    bit            err;
    int            waits;
    logic [31:0]   data;
    logic [3:0]    mask;
    logic [AW-1:0] word;
  } exp_t;

  logic [31:0]   ref_mem [0:DEPTH-1];
  exp_t          exp_q [$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            txn_id   = 0;
  logic [31:0]   pend_wdata;
  bit            last_wr_ok;
  logic [AW-1:0] last_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    @(negedge HCLK);
    while (!HREADYOUT && n < 20) begin
      n++;
      @(negedge HCLK);
    end
    if (!HREADYOUT) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: HREADYOUT stuck at 0 for %0d cycles", n);
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic issue(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, input bit commit);
    exp_t          e;
    bit            err;
    logic [3:0]    m;
    logic [AW-1:0] w;
    w   = addr[AW+1:2];
    err = (size > 3'd2) || (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00);
    if (size == 3'd0)      m = 4'b0001 << addr[1:0];
    else if (size == 3'd1) m = addr[1] ? 4'b1100 : 4'b0011;
    else                   m = 4'b1111;
    HWDATA = pend_wdata;
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HADDR  = addr;
    HSIZE  = size;
    HWRITE = wr;
    e.id       = txn_id;
    e.is_write = wr;
    e.err      = err;
    e.mask     = m;
    e.word     = w;
    e.data     = wdata;
    if (err) e.waits = 1;
    else if (!wr && last_wr_ok && last_word == w) e.waits = HAZ_WAITS;
    else e.waits = 0;
    if (!err && !wr) e.data = ref_mem[w];
    if (!err && wr && commit) ref_mem[w] = merge(ref_mem[w], wdata, m);
    txn_id++;
    exp_q.push_back(e);
    wait_accept();
    pend_wdata = wdata;
    last_wr_ok = wr && !err;
    last_word  = w;
  endtask

  task automatic idle();
    HWDATA = pend_wdata;
    HSEL   = 1'($urandom_range(0, 1));
    HTRANS = 2'b00;
    HADDR  = $urandom;
    wait_accept();
    pend_wdata = $urandom;
    last_wr_ok = 1'b0;
  endtask

  // Monitor: follows data phases on the falling edge and compares responses
  bit   dp_active = 1'b0;
  exp_t dp;
  int   dp_waits = 0;

  initial begin
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        check("rst_hresp", 32'(HRESP), 32'd0);
        check("rst_bram_write", 32'(BRAM_WRITE), 32'd0);
        check("rst_hrdata", HRDATA, 32'd0);
        dp_active = 1'b0;
        exp_q.delete();
      end else begin
        if (dp_active && dp.is_write && !dp.err && dp_waits == 0) begin
          check($sformatf("txn%0d_wr_strobe", dp.id), 32'(BRAM_WRITE), 32'(dp.mask));
          check($sformatf("txn%0d_wr_addr", dp.id), 32'(BRAM_WRADDR), 32'(dp.word));
          check($sformatf("txn%0d_wr_data", dp.id), BRAM_WDATA, dp.data);
        end else begin
          check("no_stray_write", 32'(BRAM_WRITE), 32'd0);
        end
        if (!dp_active || dp.is_write)
          check("hrdata_idle_zero", HRDATA, 32'd0);
        if (dp_active) begin
          if (!HREADYOUT) begin
            dp_waits++;
            check($sformatf("txn%0d_wait_hresp", dp.id), 32'(HRESP), 32'(dp.err));
          end else begin
            check($sformatf("txn%0d_hresp", dp.id), 32'(HRESP), 32'(dp.err));
            check($sformatf("txn%0d_waits", dp.id), 32'(dp_waits), 32'(dp.waits));
            if (!dp.err && !dp.is_write)
              check($sformatf("txn%0d_rdata", dp.id), HRDATA, dp.data);
            $display("txn %0d %s word %0d mask %b data %08h waits %0d err %0d",
                     dp.id, dp.is_write ? "WR" : "RD", dp.word, dp.mask,
                     dp.is_write ? dp.data : HRDATA, dp_waits, HRESP);
            dp_active = 1'b0;
          end
        end
        if (HREADYOUT && HSEL && HTRANS[1]) begin
          if (exp_q.size() == 0) begin
            check("unexpected_accept", 32'd1, 32'd0);
          end else begin
            dp        = exp_q.pop_front();
            dp_active = 1'b1;
            dp_waits  = 0;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rnd;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  lo;
    int          wsel;
    int          r;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(AW'(i));
    HRESET     = 1'b1;
    HSEL       = 1'b0;
    HTRANS     = 2'b00;
    HADDR      = 32'h0;
    HSIZE      = 3'd0;
    HWRITE     = 1'b0;
    HWDATA     = 32'h0;
    pend_wdata = 32'h0;
    last_wr_ok = 1'b0;
    last_word  = '0;
    repeat (3) @(posedge HCLK);
    #1;
    HRESET = 1'b0;

    // Word write then read back after an idle cycle
    issue(1'b1, 32'h0000_0010, 3'd2, 32'hDEADBEEF, 1'b1);
    idle();
    issue(1'b0, 32'h0000_0010, 3'd2, $urandom, 1'b1);
    idle();

    // Byte write into the top lane of an existing word
    issue(1'b1, 32'h0000_0010, 3'd2, 32'h11223344, 1'b1);
    issue(1'b1, 32'h0000_0013, 3'd0, 32'hAA000000, 1'b1);
    idle();
    issue(1'b0, 32'h0000_0010, 3'd2, $urandom, 1'b1);
    idle();

    // Write immediately followed by a read of the same word
    issue(1'b1, 32'h0000_0020, 3'd2, 32'h55667788, 1'b1);
    issue(1'b0, 32'h0000_0020, 3'd2, $urandom, 1'b1);
    idle();

    // Misaligned transfers produce the two-cycle ERROR response
    issue(1'b0, 32'h0000_0002, 3'd2, $urandom, 1'b1);
    issue(1'b0, 32'h0000_0004, 3'd2, $urandom, 1'b1);
    issue(1'b1, 32'h0000_0011, 3'd1, 32'h12345678, 1'b1);
    issue(1'b1, 32'h0000_0008, 3'd3, 32'h87654321, 1'b1);
    issue(1'b0, 32'h0000_0010, 3'd2, $urandom, 1'b1);
    idle();

    // Reset asserted during a write data phase discards the write
    issue(1'b1, 32'h0000_0030, 3'd2, 32'hCAFEF00D, 1'b0);
    HRESET = 1'b1;
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    repeat (2) @(posedge HCLK);
    #1;
    HRESET     = 1'b0;
    last_wr_ok = 1'b0;
    issue(1'b0, 32'h0000_0030, 3'd2, $urandom, 1'b1);
    idle();

    // Randomized traffic over a few words so hazards occur often
    repeat (400) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        idle();
      end else begin
        rnd  = $urandom;
        wsel = $urandom_range(0, 7);
        size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        lo   = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) begin
          if (size == 3'd1) lo[0] = 1'b0;
          if (size == 3'd2) lo = 2'b00;
        end
        addr = (rnd & 32'hFFFF_0000) | (32'(wsel) << 2) | 32'(lo);
        issue(1'($urandom_range(0, 1)), addr, size, $urandom, 1'b1);
      end
    end
    repeat (3) idle();
    check("scoreboard_drained", 32'(exp_q.size()) + 32'(dp_active), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
